// File: rtl/commit_unit.sv
// In-order retirement stage behind the reorder buffer: retires the ROB head, writes RF/RAT,
// completes loads/stores through the LSQ and raises a flush on a mispredicted branch.
//
// state      | meaning
// IDLE       | out of reset, no retirement
// RUN        | observing ROB head, retiring ALU/branch ops, issuing LSQ requests
// LOAD_WAIT  | holding load request until LSQ returns data
// STORE_WAIT | holding store release until LSQ acknowledges
// FLUSH      | one recovery cycle while the ROB clears
module commit_unit #(
  parameter int ROBSIZE     = 8,
  parameter int RET_CNT_W   = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_head_ready,
  input  logic [ROBSIZE-1:0]     i_head_rob_addr,
  input  logic [31:0]            i_head_pc,
  input  logic [31:0]            i_head_value,
  input  logic [4:0]             i_head_rd,
  input  logic                   i_head_exception,
  input  logic [1:0]             i_head_load_store,
  input  logic                   i_head_rd_inst,
  input  logic [2:0]             i_head_cont_tra,
  output logic                   o_commit,
  output logic                   o_rf_we,
  output logic [4:0]             o_rf_addr,
  output logic [31:0]            o_rf_data,
  output logic                   o_rat_clr,
  output logic [4:0]             o_rat_rd,
  output logic [ROBSIZE-1:0]     o_rat_rob_addr,
  output logic                   o_lsq_load_req,
  input  logic                   i_lsq_load_valid,
  input  logic [31:0]            i_lsq_load_data,
  output logic                   o_lsq_store_req,
  input  logic                   i_lsq_store_ack,
  output logic [ROBSIZE-1:0]     o_lsq_rob_addr,
  output logic                   o_flush,
  output logic                   o_redirect_valid,
  output logic [31:0]            o_redirect_pc,
  output logic                   o_redirect_taken,
  output logic [RET_CNT_W-1:0]   o_retired_count,
  output logic [FLUSH_CNT_W-1:0] o_flush_count
);

  typedef enum logic [2:0] {IDLE, RUN, LOAD_WAIT, STORE_WAIT, FLUSH} state_t;

  state_t                 r_state;
  logic [ROBSIZE-1:0]     r_tag;
  logic [4:0]             r_rd;
  logic [RET_CNT_W-1:0]   r_ret_cnt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;

  logic w_run_go, w_exc, w_alu, w_ld_issue, w_st_issue;
  logic w_ld_done, w_st_done, w_commit, w_wr_alu, w_wr_ld;
  logic w_unused;

  // Control-transfer type is not needed: the ROB already folds mispredicts into the exception flag.
  assign w_unused   = ^i_head_cont_tra;

  assign w_run_go   = (r_state == RUN) & i_head_ready;
  assign w_exc      = w_run_go & i_head_exception;
  assign w_ld_issue = w_run_go & ~i_head_exception & (i_head_load_store == 2'b01);
  assign w_st_issue = w_run_go & ~i_head_exception & (i_head_load_store == 2'b10);
  assign w_alu      = w_run_go & ~i_head_exception & ~w_ld_issue & ~w_st_issue;
  assign w_ld_done  = (r_state == LOAD_WAIT) & i_lsq_load_valid & i_head_ready;
  assign w_st_done  = (r_state == STORE_WAIT) & i_lsq_store_ack & i_head_ready;
  assign w_commit   = w_alu | w_ld_done | w_st_done;
  assign w_wr_alu   = w_alu & i_head_rd_inst & (i_head_rd != 5'd0);
  assign w_wr_ld    = w_ld_done & (r_rd != 5'd0);

  always_comb begin
    o_commit         = w_commit;
    o_rf_we          = w_wr_alu | w_wr_ld;
    o_rf_addr        = 5'd0;
    o_rf_data        = 32'd0;
    o_rat_rob_addr   = '0;
    if (w_wr_alu) begin
      o_rf_addr      = i_head_rd;
      o_rf_data      = i_head_value;
      o_rat_rob_addr = i_head_rob_addr;
    end else if (w_wr_ld) begin
      o_rf_addr      = r_rd;
      o_rf_data      = i_lsq_load_data;
      o_rat_rob_addr = r_tag;
    end
    o_rat_clr        = o_rf_we;
    o_rat_rd         = o_rf_addr;
    o_lsq_load_req   = w_ld_issue | (r_state == LOAD_WAIT);
    o_lsq_store_req  = w_st_issue | (r_state == STORE_WAIT);
    o_lsq_rob_addr   = '0;
    if (w_ld_issue || w_st_issue)
      o_lsq_rob_addr = i_head_rob_addr;
    else if (r_state == LOAD_WAIT || r_state == STORE_WAIT)
      o_lsq_rob_addr = r_tag;
    o_flush          = w_exc;
    o_redirect_valid = w_exc;
    o_redirect_pc    = w_exc ? i_head_pc : 32'd0;
    o_redirect_taken = w_exc & i_head_value[0];
    o_retired_count  = r_ret_cnt;
    o_flush_count    = r_flush_cnt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_tag       <= '0;
      r_rd        <= 5'd0;
      r_ret_cnt   <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        IDLE:       r_state <= RUN;
        RUN: begin
          if (w_exc)           r_state <= FLUSH;
          else if (w_ld_issue) r_state <= LOAD_WAIT;
          else if (w_st_issue) r_state <= STORE_WAIT;
        end
        LOAD_WAIT:  if (w_ld_done) r_state <= RUN;
        STORE_WAIT: if (w_st_done) r_state <= RUN;
        FLUSH:      r_state <= RUN;
        default:    r_state <= IDLE;
      endcase
      // Tag and rd are captured so the wait states do not depend on the head staying stable.
      if (w_ld_issue || w_st_issue) begin
        r_tag <= i_head_rob_addr;
        r_rd  <= i_head_rd;
      end
      if (w_commit)
        r_ret_cnt <= r_ret_cnt + RET_CNT_W'(1);
      if (w_exc && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + FLUSH_CNT_W'(1);
    end
  end

endmodule
